// File: rtl/uart8_tx_feeder.sv
// uart8_tx_feeder: FIFO-buffered byte feeder driving a Uart8 transmitter through a level start/busy handshake
//   clk, reset                          : board clock, asynchronous active-high reset
//   en, inValid, inData, inReady        : byte input stream (valid/ready); en allows draining to the transmitter
//   count, active, timeoutErr           : bytes queued, byte in flight, sticky start-timeout flag
//   txEn, txStart, txIn, txBusy, txDone : Uart8 transmit port
module uart8_tx_feeder #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     inValid,
  input  logic [7:0]               inData,
  output logic                     inReady,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic                     active,
  output logic                     timeoutErr,
  output logic                     txEn,
  output logic                     txStart,
  output logic [7:0]               txIn,
  input  logic                     txBusy,
  input  logic                     txDone
);
  localparam int W = FIFO_ADDR_WIDTH;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(START_TIMEOUT - 1);
  localparam logic [W:0] FULL = {1'b1, {W{1'b0}}};
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, GAP = 2'd3;
  logic [7:0] r_mem [2**W];
  logic [W:0] r_wptr, r_rptr, r_count, w_wptr_n, w_rptr_n;
  logic [1:0] r_state, w_state_n;
  logic [TW-1:0] r_tmo;
  logic [7:0] r_txin;
  logic r_ready, r_busy_m, r_busy_s, r_err;
  logic w_empty, w_push, w_pop, w_timeout, w_active, w_unused;
  assign w_unused = txDone;
  assign w_empty = r_wptr == r_rptr;
  assign w_push = inValid & r_ready;
  assign w_pop = (r_state == IDLE) & en & !w_empty;
  assign w_wptr_n = r_wptr + (W+1)'(w_push);
  assign w_rptr_n = r_rptr + (W+1)'(w_pop);
  assign w_timeout = r_tmo == TMAX;
  // busy is checked before the timeout so a late accept still wins on the last START cycle
  assign w_state_n = r_state == IDLE  ? (w_pop ? START : IDLE) :
                     r_state == START ? (r_busy_s ? WAIT : w_timeout ? IDLE : START) :
                     r_state == WAIT  ? (r_busy_s ? WAIT : GAP) : IDLE;
  assign w_active = r_state != IDLE;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[W-1:0]] <= inData;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
      r_state <= IDLE;
      r_tmo <= '0;
      r_err <= 1'b0;
      r_txin <= 8'h00;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_count <= w_wptr_n - w_rptr_n;
      // ready is computed from the next pointers so it never lags a fill
      r_ready <= (w_wptr_n ^ w_rptr_n) != FULL;
      r_busy_m <= txBusy;
      r_busy_s <= r_busy_m;
      r_state <= w_state_n;
      r_tmo <= r_state == START ? r_tmo + TW'(1) : '0;
      r_err <= r_err | ((r_state == START) & !r_busy_s & w_timeout);
      r_txin <= w_pop ? r_mem[r_rptr[W-1:0]] : r_txin;
    end
  assign inReady = r_ready;
  assign count = r_count;
  assign active = w_active;
  assign timeoutErr = r_err;
  assign txEn = en | w_active;
  assign txStart = r_state == START;
  assign txIn = r_txin;
endmodule

// File: tb/tb_uart8_tx_feeder.sv
// tb_uart8_tx_feeder: directed/randomized bench with a behavioural Uart8 transmitter and queue-based reference
module tb_uart8_tx_feeder;
  localparam int W = 4, T = 20;
  logic clk = 0, reset = 1, en = 0, inValid = 0, txBusy = 0, txDone = 0;
  logic [7:0] inData = 0, txIn;
  logic inReady, active, timeoutErr, txEn, txStart;
  logic [W:0] count;
  int n_err = 0, n_chk = 0;
  int m_delay = 3, m_hold = 100;
  bit m_never = 0;
  byte unsigned q_exp[$], q_acc[$], q_start[$];
  int ph = 0, cnt = 0, run = 0, last_run = 0, stab_err = 0;
  logic ps = 0, pa = 0;
  logic [7:0] pt = 0;
  always #5 clk = ~clk;
  uart8_tx_feeder #(.FIFO_ADDR_WIDTH(W), .START_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .en(en), .inValid(inValid), .inData(inData), .inReady(inReady),
    .count(count), .active(active), .timeoutErr(timeoutErr), .txEn(txEn), .txStart(txStart),
    .txIn(txIn), .txBusy(txBusy), .txDone(txDone)
  );
  // transmitter model: latches txIn on a start, raises busy m_delay cycles later for m_hold cycles
  initial begin
    forever begin
      @(posedge clk);
      #1;
      txDone = 0;
      if (reset) begin
        txBusy = 0;
        ph = 0;
        run = 0;
        ps = 0;
        pa = 0;
        continue;
      end
      if (txStart && !ps) q_start.push_back(txIn);
      if (txStart) run++;
      else begin
        if (ps) last_run = run;
        run = 0;
      end
      if (active && pa && txIn !== pt) stab_err++;
      ps = txStart;
      pa = active;
      pt = txIn;
      if (ph == 0) begin
        if (txStart && !m_never) begin
          q_acc.push_back(txIn);
          cnt = m_delay;
          ph = 1;
        end
      end else if (ph == 1) begin
        cnt--;
        if (cnt == 0) begin
          txBusy = 1;
          cnt = m_hold;
          ph = 2;
        end
      end else begin
        cnt--;
        if (cnt == 0) begin
          txBusy = 0;
          txDone = 1;
          ph = 0;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [7:0] d);
    int k = 0;
    while (!inReady && k < 2000) begin
      step();
      k++;
    end
    chk("push_ready_wait", k < 2000, 1);
    inValid = 1;
    inData = d;
    step();
    inValid = 0;
    q_exp.push_back(d);
  endtask
  task automatic drain(input string tag, input int lim);
    int k = 0;
    while ((active || count != 0) && k < lim) begin
      step();
      k++;
    end
    chk(tag, k < lim, 1);
  endtask
  task automatic cmp_seq(input string tag, input byte unsigned got[$], input byte unsigned exp[$]);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) chk(tag, i < got.size() ? 32'(got[i]) : 32'h100, exp[i]);
  endtask
  initial begin
    int k, bad, ns;
    logic [7:0] a, b, c;
    repeat (3) step();
    chk("rst_inReady", inReady, 0);
    chk("rst_count", count, 0);
    chk("rst_active", active, 0);
    chk("rst_timeoutErr", timeoutErr, 0);
    chk("rst_txEn", txEn, 0);
    chk("rst_txStart", txStart, 0);
    chk("rst_txIn", txIn, 0);
    reset = 0;
    step();
    chk("rel_inReady", inReady, 1);
    // single byte with a slow transmitter
    en = 1;
    push(8'h55);
    chk("t1_count_after_push", count, 1);
    step();
    chk("t1_txStart", txStart, 1);
    chk("t1_txIn", txIn, 8'h55);
    chk("t1_count_popped", count, 0);
    k = 0;
    while (!txDone && k < 300) begin
      step();
      k++;
    end
    chk("t1_busy_end", k < 300, 1);
    k = 0;
    while (active && k < 50) begin
      step();
      k++;
    end
    chk("t1_active_drop_latency", k, 4);
    chk("t1_start_len", last_run, m_delay + 3);
    chk("t1_sent", q_acc.size() > 0 ? 32'(q_acc[$]) : 32'h100, 8'h55);
    chk("t1_count_end", count, 0);
    // fill to full with draining off
    en = 0;
    m_hold = $urandom_range(5, 12);
    q_exp.delete();
    q_acc.delete();
    q_start.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_count_full", count, 16);
    chk("t2_inReady_full", inReady, 0);
    inValid = 1;
    inData = 8'hAA;
    step();
    step();
    inValid = 0;
    chk("t2_count_17th", count, 16);
    en = 1;
    drain("t2_drain", 3000);
    cmp_seq("t2_order", q_acc, q_exp);
    cmp_seq("t2_starts", q_start, q_exp);
    // simultaneous push/pop, then enough traffic to wrap the pointers
    en = 0;
    q_exp.delete();
    q_acc.delete();
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
    chk("t3_count5", count, 5);
    en = 1;
    inValid = 1;
    inData = 8'($urandom_range(0, 255));
    q_exp.push_back(inData);
    step();
    inValid = 0;
    en = 0;
    chk("t3_pushpop_count", count, 5);
    chk("t3_pushpop_active", active, 1);
    en = 1;
    for (int i = 0; i < 34; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push(8'($urandom_range(0, 255)));
    end
    drain("t3_drain", 4000);
    cmp_seq("t3_order", q_acc, q_exp);
    chk("t3_txIn_stable", stab_err, 0);
    // start timeout: transmitter never answers
    m_never = 1;
    q_acc.delete();
    q_start.delete();
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    push(a);
    push(b);
    drain("t4_drain", 200);
    chk("t4_start_len", last_run, T);
    chk("t4_timeoutErr", timeoutErr, 1);
    chk("t4_none_accepted", q_acc.size(), 0);
    chk("t4_starts", q_start.size(), 2);
    chk("t4_start_a", q_start.size() > 0 ? 32'(q_start[0]) : 32'h100, a);
    chk("t4_start_b", q_start.size() > 1 ? 32'(q_start[1]) : 32'h100, b);
    m_never = 0;
    push(c);
    drain("t4_drain2", 300);
    chk("t4_next_sent", q_acc.size() > 0 ? 32'(q_acc[$]) : 32'h100, c);
    chk("t4_err_sticky", timeoutErr, 1);
    // drop en mid-frame
    m_hold = 40;
    q_acc.delete();
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    push(a);
    k = 0;
    while (!txStart && k < 20) begin
      step();
      k++;
    end
    chk("t5_start_seen", k < 20, 1);
    en = 0;
    #1;
    chk("t5_txEn_inflight", txEn, 1);
    push(b);
    k = 0;
    bad = 0;
    while (active && k < 300) begin
      if (!txEn) bad++;
      step();
      k++;
    end
    chk("t5_frame_end", k < 300, 1);
    chk("t5_txEn_held", bad, 0);
    chk("t5_txEn_idle", txEn, 0);
    repeat (5) step();
    chk("t5_no_pop_count", count, 1);
    chk("t5_no_pop_active", active, 0);
    en = 1;
    drain("t5_drain", 300);
    chk("t5_sent_len", q_acc.size(), 2);
    chk("t5_sent_b", q_acc.size() > 1 ? 32'(q_acc[1]) : 32'h100, b);
    // reset while in WAIT with three bytes queued
    en = 0;
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    en = 1;
    step();
    en = 0;
    chk("t6_count3", count, 3);
    k = 0;
    while (!txBusy && k < 50) begin
      step();
      k++;
    end
    chk("t6_busy_seen", k < 50, 1);
    repeat (4) step();
    chk("t6_in_frame", active, 1);
    #1 reset = 1;
    #1;
    chk("t6_count", count, 0);
    chk("t6_active", active, 0);
    chk("t6_txStart", txStart, 0);
    chk("t6_txEn", txEn, 0);
    chk("t6_txIn", txIn, 0);
    chk("t6_inReady", inReady, 0);
    chk("t6_timeoutErr", timeoutErr, 0);
    repeat (3) step();
    reset = 0;
    ns = q_start.size();
    en = 1;
    repeat (60) step();
    chk("t6_nothing_sent", q_start.size(), ns);
    chk("t6_count_after", count, 0);
    chk("t6_active_after", active, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
